// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Writes on Wr_En push Wr_Data[7:0]. A 4-state FSM pops bytes and shifts
// them out LSB first on Tx, with CLKS_PER_BIT clocks per bit.
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   Wr_En        - write strobe; Wr_Data[7:0] is pushed if there is room
//   Wr_Data      - bus write data (upper bits ignored)
//   Clr_Ovf      - clears the sticky Overflow flag
//   Tx           - serial line, idle high
//   Tx_Busy      - frame in progress or bytes pending
//   Fifo_Full    - FIFO status flag
//   Fifo_Empty   - FIFO status flag
//   Overflow     - sticky dropped-write flag
//   Status       - {0.., count[4:0], Overflow, Fifo_Empty, Fifo_Full, Tx_Busy}
module mmio_uart_tx #(
  parameter int DATA_LENGTH  = 32,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Wr_En,
  input  logic [DATA_LENGTH-1:0] Wr_Data,
  input  logic                   Clr_Ovf,
  output logic                   Tx,
  output logic                   Tx_Busy,
  output logic                   Fifo_Full,
  output logic                   Fifo_Empty,
  output logic                   Overflow,
  output logic [DATA_LENGTH-1:0] Status
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_n;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [BW-1:0]  baud, baud_n;
  logic [2:0]     bit_idx, bit_n;
  logic [7:0]     shift, shift_n;
  logic           tx_q, tx_n;
  logic           ovf_q;
  logic           pop, push, drop;
  logic           unused_wr_hi;

  assign unused_wr_hi = ^Wr_Data[DATA_LENGTH-1:8];

  assign Fifo_Full  = (count == CNT_FULL);
  assign Fifo_Empty = (count == '0);
  assign Tx         = tx_q;
  assign Overflow   = ovf_q;
  assign Tx_Busy    = (state != IDLE) | ~Fifo_Empty;
  assign Status     = {{(DATA_LENGTH-9){1'b0}}, 5'(count), ovf_q, Fifo_Empty, Fifo_Full, Tx_Busy};

  // A pop frees a slot on the same edge, so a write to a full FIFO is only
  // dropped when the FSM is not popping.
  assign pop  = (state == IDLE) && !Fifo_Empty;
  assign push = Wr_En && (!Fifo_Full || pop);
  assign drop = Wr_En && Fifo_Full && !pop;

  // Storage has no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= Wr_Data[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (Clr_Ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // Tx is registered: each branch loads the level for the next bit period.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    case (state)
      IDLE: if (pop) begin
        shift_n = mem[rd_ptr];
        baud_n  = '0;
        bit_n   = '0;
        tx_n    = 1'b0;
        state_n = START;
      end
      START: if (baud == BAUD_MAX) begin
        baud_n  = '0;
        tx_n    = shift[0];
        state_n = DATA;
      end else baud_n = baud + BW'(1);
      DATA: if (baud == BAUD_MAX) begin
        baud_n = '0;
        if (bit_idx == 3'd7) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          bit_n   = bit_idx + 3'd1;
          shift_n = {1'b0, shift[7:1]};
          tx_n    = shift[1];
        end
      end else baud_n = baud + BW'(1);
      STOP: if (baud == BAUD_MAX) begin
        baud_n  = '0;
        state_n = IDLE;
      end else baud_n = baud + BW'(1);
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
  localparam int DL    = 32;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 0, reset = 0, Wr_En = 0, Clr_Ovf = 0;
  logic [DL-1:0] Wr_Data = '0;
  logic          Tx, Tx_Busy, Fifo_Full, Fifo_Empty, Overflow;
  logic [DL-1:0] Status;

  mmio_uart_tx #(.DATA_LENGTH(DL), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Wr_En(Wr_En), .Wr_Data(Wr_Data), .Clr_Ovf(Clr_Ovf),
    .Tx(Tx), .Tx_Busy(Tx_Busy), .Fifo_Full(Fifo_Full), .Fifo_Empty(Fifo_Empty),
    .Overflow(Overflow), .Status(Status)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus frame timing. A byte is popped when
  // the line has been free for a full frame plus one idle cycle; the line
  // level is read off the frame {stop, data, start} by elapsed cycles.
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int         cyc = 0, last_pop = -100000;
  bit         m_ovf = 0;

  task automatic model_reset();
    q.delete();
    last_pop = -100000;
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit we, input logic [7:0] d, input bit clr);
    bit pop_m, set_o;
    pop_m = (q.size() > 0) && (cyc >= last_pop + FRAME + 1);
    set_o = 0;
    if (pop_m) begin
      cur = q.pop_front();
      last_pop = cyc;
    end
    if (we) begin
      if (q.size() < DEPTH) q.push_back(d);
      else set_o = 1;
    end
    if (set_o) m_ovf = 1;
    else if (clr) m_ovf = 0;
    cyc++;
  endtask

  function automatic bit model_active();
    return (cyc - 1 - last_pop) < FRAME;
  endfunction

  task automatic model_check();
    logic [9:0]  fr;
    logic        etx, ebusy, efull, eempty;
    logic [31:0] est;
    int          k;
    k = cyc - 1 - last_pop;
    fr = {1'b1, cur, 1'b0};
    etx = model_active() ? fr[k / CPB] : 1'b1;
    ebusy = model_active() || (q.size() > 0);
    efull = (q.size() == DEPTH);
    eempty = (q.size() == 0);
    est = {23'b0, 5'(q.size()), m_ovf, eempty, efull, ebusy};
    chk("m_tx", Tx, etx);
    chk("m_busy", Tx_Busy, ebusy);
    chk("m_full", Fifo_Full, efull);
    chk("m_empty", Fifo_Empty, eempty);
    chk("m_ovf", Overflow, m_ovf);
    chk("m_status", Status, est);
  endtask

  task automatic step(input bit we, input logic [31:0] wd, input bit clr);
    @(negedge clk);
    Wr_En = we; Wr_Data = wd; Clr_Ovf = clr;
    @(posedge clk);
    model_edge(we, wd[7:0], clr);
    #1;
    Wr_En = 0; Wr_Data = '0; Clr_Ovf = 0;
    model_check();
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (q.size() > 0 || model_active()); i++) step(0, 0, 0);
  endtask

  typedef struct {
    logic [31:0] wdata;
    logic [9:0]  frame;  // bit i = line level in segment i (start first)
  } vec_t;
  vec_t vecs[4];

  initial begin
    int burst;
    vecs[0] = '{32'h000000A5, 10'b1_10100101_0};
    vecs[1] = '{32'hDEADBE3C, 10'b1_00111100_0};
    vecs[2] = '{32'hFFFFFF80, 10'b1_10000000_0};
    vecs[3] = '{32'h123456FF, 10'b1_11111111_0};

    // Asynchronous reset, checked between edges.
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("rst_tx", Tx, 1);
    chk("rst_status", Status, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    model_reset();

    // Table-driven single frames.
    foreach (vecs[n]) begin
      drain();
      step(1, vecs[n].wdata, 0);
      chk("cap_tx", Tx, 1);
      chk("cap_busy", Tx_Busy, 1);
      for (int j = 0; j < FRAME; j++) begin
        step(0, 0, 0);
        chk("frame_tx", Tx, vecs[n].frame[j / CPB]);
        if (j == FRAME - 1) chk("busy_last", Tx_Busy, 1);
      end
      step(0, 0, 0);
      chk("busy_end", Tx_Busy, 0);
      chk("idle_tx", Tx, 1);
    end

    // Back-to-back writes with pointer wrap.
    drain();
    step(1, 32'h11, 0); step(1, 32'h22, 0); step(1, 32'h33, 0);
    step(1, 32'h44, 0); step(1, 32'h55, 0);
    chk("b2b_no_ovf", Overflow, 0);
    chk("b2b_full", Fifo_Full, 1);
    drain();

    // Overflow set/clear/priority.
    step(1, 32'hA0, 0); step(0, 0, 0);
    step(1, 32'hB1, 0); step(1, 32'hB2, 0); step(1, 32'hB3, 0); step(1, 32'hB4, 0);
    step(1, 32'h99, 0);
    chk("ovf_set", Overflow, 1);
    chk("ovf_stat", Status[3], 1);
    step(0, 0, 1);
    chk("ovf_clr", Overflow, 0);
    step(1, 32'h77, 1);
    chk("ovf_set_wins", Overflow, 1);
    step(0, 0, 1);
    drain();

    // Randomized traffic against the model.
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      bit we;
      if ($urandom_range(0, 199) == 0) burst = 6;
      we = (burst > 0) || ($urandom_range(0, 24) == 0);
      if (burst > 0) burst--;
      step(we, $urandom, $urandom_range(0, 39) == 0);
    end
    drain();

    // Reset during data bit 3 with two bytes queued.
    step(1, 32'hC1, 0); step(1, 32'hC2, 0); step(1, 32'hC3, 0);
    repeat (16) step(0, 0, 0);
    #2 reset = 1;
    #1;
    chk("mrst_tx", Tx, 1);
    chk("mrst_empty", Fifo_Empty, 1);
    chk("mrst_status", Status, 32'h4);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    repeat (100) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
